// File: rtl/idex_pkg.sv
// Shared definitions for the ID/EX pipeline register: state encoding and bundle layout.
package idex_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int IDEX_CTRL_BITS  = 4;
  localparam int IDEX_FUNC3_BITS = 3;
  localparam int IDEX_FUNC7_BITS = 1;
  localparam int IDEX_DATA_WORDS = 3;

  // Flat bundle width; field order MSB..LSB follows idex_bundle_t.
  function automatic int idex_bundle_w(input int data_w, input int reg_w);
    return IDEX_CTRL_BITS + IDEX_FUNC3_BITS + IDEX_FUNC7_BITS
           + IDEX_DATA_WORDS * data_w + reg_w;
  endfunction

  typedef struct packed {
    logic        wreg_en;
    logic        wmem_en;
    logic        rs2_swch;
    logic        mem_to_reg;
    logic [2:0]  func3;
    logic        func7;
    logic [15:0] r1out;
    logic [15:0] r2out;
    logic [15:0] sign_ext;
    logic [4:0]  wreg1;
  } idex_bundle_t;

endpackage

// File: rtl/idex_skid_buf.sv
// Width-generic skid storage: a single load-enabled register cleared by reset.
module idex_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_r;

  // Skid data register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      data_r <= {WIDTH{1'b0}};
    end else if (load) begin
      data_r <= d;
    end
  end

  assign q = data_r;

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline stage: two-entry (main + skid) elastic register with load-use hazard detect.
module idex_stage
  import idex_pkg::*;
#(
  parameter int PROC_DATA_WIDTH        = 16,
  parameter int PROC_REGFILE_LOG2_DEEP = 5
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              flush,
  input  logic                              WRegEn_in,
  input  logic                              WMemEn_in,
  input  logic                              rs2_swch_in,
  input  logic                              mem_to_reg_in,
  input  logic                              func7_in,
  input  logic [2:0]                        func3_in,
  input  logic [PROC_DATA_WIDTH-1:0]        R1out_in,
  input  logic [PROC_DATA_WIDTH-1:0]        R2out_in,
  input  logic [PROC_DATA_WIDTH-1:0]        sign_ext_in,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] WReg1_in,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] id_rs1,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] id_rs2,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              WRegEn_out,
  output logic                              WMemEn_out,
  output logic                              rs2_swch_out,
  output logic                              mem_to_reg_out,
  output logic                              func7_out,
  output logic [2:0]                        func3_out,
  output logic [PROC_DATA_WIDTH-1:0]        R1out_out,
  output logic [PROC_DATA_WIDTH-1:0]        R2out_out,
  output logic [PROC_DATA_WIDTH-1:0]        sign_ext_out,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] WReg1_out,
  output logic                              hz_load_use,
  output logic [1:0]                        occupancy
);

  localparam int DW    = PROC_DATA_WIDTH;
  localparam int RW    = PROC_REGFILE_LOG2_DEEP;
  localparam int BW    = idex_bundle_w(DW, RW);
  localparam int O_SE  = RW;
  localparam int O_R2  = RW + DW;
  localparam int O_R1  = RW + 2 * DW;
  localparam int O_F7  = RW + 3 * DW;
  localparam int O_F3  = O_F7 + 1;
  localparam int O_M2R = O_F3 + 3;
  localparam int O_RS2 = O_M2R + 1;
  localparam int O_WM  = O_RS2 + 1;
  localparam int O_WE  = O_WM + 1;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic          in_ready_r;
  logic [BW-1:0] main_r;
  logic [BW-1:0] main_d_s;
  logic [BW-1:0] skid_q_s;
  logic [BW-1:0] in_bundle_s;
  logic          main_load_s;
  logic          main_from_skid_s;
  logic          skid_load_s;
  logic          main_valid_s;
  logic          skid_valid_s;
  logic          accept_s;
  logic          release_s;
  logic [RW-1:0] main_wreg_s;

  // Register 0 is never a write target, so its write enable is dropped on entry.
  assign in_bundle_s = {WRegEn_in && (WReg1_in != {RW{1'b0}}), WMemEn_in, rs2_swch_in,
                        mem_to_reg_in, func3_in, func7_in, R1out_in, R2out_in,
                        sign_ext_in, WReg1_in};

  assign main_valid_s = (state_r != ST_EMPTY);
  assign skid_valid_s = (state_r == ST_FULL);
  assign accept_s     = in_valid && in_ready_r;
  assign release_s    = main_valid_s && out_ready;
  assign main_d_s     = main_from_skid_s ? skid_q_s : in_bundle_s;

  // Next-state and load-enable decode; flush wins over accept and release.
  always_comb begin
    state_nxt_s      = state_r;
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ST_ONE;
            main_load_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && release_s) begin
            state_nxt_s = ST_ONE;
            main_load_s = 1'b1;
          end else if (accept_s) begin
            state_nxt_s = ST_FULL;
            skid_load_s = 1'b1;
          end else if (release_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (release_s) begin
            state_nxt_s      = ST_ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // State, main bundle and registered ready.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r    <= ST_EMPTY;
      main_r     <= {BW{1'b0}};
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s != ST_FULL);
      if (main_load_s) begin
        main_r <= main_d_s;
      end
    end
  end

  idex_skid_buf #(
    .WIDTH (BW)
  ) u_skid (
    .CLK   (CLK),
    .RST_N (RST_N),
    .load  (skid_load_s),
    .d     (in_bundle_s),
    .q     (skid_q_s)
  );

  assign in_ready       = in_ready_r;
  assign out_valid      = main_valid_s;
  assign occupancy      = {1'b0, main_valid_s} + {1'b0, skid_valid_s};
  assign WRegEn_out     = main_r[O_WE]  && main_valid_s;
  assign WMemEn_out     = main_r[O_WM]  && main_valid_s;
  assign mem_to_reg_out = main_r[O_M2R] && main_valid_s;
  assign rs2_swch_out   = main_r[O_RS2];
  assign func3_out      = main_r[O_F3 +: 3];
  assign func7_out      = main_r[O_F7];
  assign R1out_out      = main_r[O_R1 +: DW];
  assign R2out_out      = main_r[O_R2 +: DW];
  assign sign_ext_out   = main_r[O_SE +: DW];
  assign main_wreg_s    = main_r[RW-1:0];
  assign WReg1_out      = main_wreg_s;

  assign hz_load_use = !flush && main_valid_s && main_r[O_M2R]
                       && (main_wreg_s != {RW{1'b0}})
                       && ((main_wreg_s == id_rs1) || (main_wreg_s == id_rs2));

endmodule

// File: tb/tb_idex_stage.sv
// Directed + random bench for idex_stage against a queue-based reference model.
module tb_idex_stage;

  typedef struct packed {
    logic        we;
    logic        wm;
    logic        rs2;
    logic        m2r;
    logic [2:0]  f3;
    logic        f7;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] se;
    logic [4:0]  wr;
  } bnd_t;

  logic        CLK;
  logic        RST_N;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        WRegEn_in, WMemEn_in, rs2_swch_in, mem_to_reg_in, func7_in;
  logic [2:0]  func3_in;
  logic [15:0] R1out_in, R2out_in, sign_ext_in;
  logic [4:0]  WReg1_in;
  logic [4:0]  id_rs1, id_rs2;
  logic        out_valid;
  logic        out_ready;
  logic        WRegEn_out, WMemEn_out, rs2_swch_out, mem_to_reg_out, func7_out;
  logic [2:0]  func3_out;
  logic [15:0] R1out_out, R2out_out, sign_ext_out;
  logic [4:0]  WReg1_out;
  logic        hz_load_use;
  logic [1:0]  occupancy;

  int   n_vec  = 0;
  int   n_fail = 0;
  bnd_t q[$];
  bnd_t last;
  bnd_t cur;

  idex_stage dut (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .WRegEn_in(WRegEn_in), .WMemEn_in(WMemEn_in), .rs2_swch_in(rs2_swch_in),
    .mem_to_reg_in(mem_to_reg_in), .func7_in(func7_in), .func3_in(func3_in),
    .R1out_in(R1out_in), .R2out_in(R2out_in), .sign_ext_in(sign_ext_in),
    .WReg1_in(WReg1_in), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .WRegEn_out(WRegEn_out), .WMemEn_out(WMemEn_out), .rs2_swch_out(rs2_swch_out),
    .mem_to_reg_out(mem_to_reg_out), .func7_out(func7_out), .func3_out(func3_out),
    .R1out_out(R1out_out), .R2out_out(R2out_out), .sign_ext_out(sign_ext_out),
    .WReg1_out(WReg1_out), .hz_load_use(hz_load_use), .occupancy(occupancy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bnd_t mk(input logic m2r, input logic [15:0] r1, input logic [4:0] wr);
    bnd_t b;
    b = '0;
    b.we  = 1'b1;
    b.m2r = m2r;
    b.r1  = r1;
    b.r2  = ~r1;
    b.se  = r1 ^ 16'h5A5A;
    b.f3  = r1[2:0];
    b.wr  = wr;
    return b;
  endfunction

  function automatic bnd_t rnd_bnd();
    bnd_t b;
    b.we  = 1'($urandom_range(0, 1));
    b.wm  = 1'($urandom_range(0, 1));
    b.rs2 = 1'($urandom_range(0, 1));
    b.m2r = 1'($urandom_range(0, 1));
    b.f3  = 3'($urandom);
    b.f7  = 1'($urandom_range(0, 1));
    b.r1  = 16'($urandom);
    b.r2  = 16'($urandom);
    b.se  = 16'($urandom);
    b.wr  = 5'($urandom_range(0, 7));
    return b;
  endfunction

  task automatic apply(input bnd_t b, input logic v);
    cur           = b;
    in_valid      = v;
    WRegEn_in     = b.we;
    WMemEn_in     = b.wm;
    rs2_swch_in   = b.rs2;
    mem_to_reg_in = b.m2r;
    func3_in      = b.f3;
    func7_in      = b.f7;
    R1out_in      = b.r1;
    R2out_in      = b.r2;
    sign_ext_in   = b.se;
    WReg1_in      = b.wr;
  endtask

  function automatic logic model_hz();
    return (q.size() > 0) && last.m2r && (last.wr != 5'd0)
           && ((last.wr == id_rs1) || (last.wr == id_rs2)) && !flush;
  endfunction

  task automatic check_all();
    bnd_t exp, obs;
    exp = last;
    if (q.size() == 0) begin
      exp.we  = 1'b0;
      exp.wm  = 1'b0;
      exp.m2r = 1'b0;
    end
    obs = {WRegEn_out, WMemEn_out, rs2_swch_out, mem_to_reg_out, func3_out, func7_out,
           R1out_out, R2out_out, sign_ext_out, WReg1_out};
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("hz_load_use", 64'(hz_load_use), 64'(model_hz()));
    check("bundle", 64'(obs), 64'(exp));
  endtask

  // One clock: model the FIFO-of-two semantics, then compare everything.
  task automatic cycle();
    bit   acc, rel;
    bnd_t nb;
    acc = in_valid && (q.size() < 2);
    rel = (q.size() > 0) && out_ready;
    nb = cur;
    nb.we = cur.we && (cur.wr != 5'd0);
    @(posedge CLK);
    if (!RST_N) begin
      q.delete();
      last = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      if (rel) void'(q.pop_front());
      if (acc) q.push_back(nb);
    end
    if (q.size() > 0) last = q[0];
    #1;
    check_all();
  endtask

  initial begin
    bnd_t a, b, c, d;
    last = '0;
    RST_N = 1'b0; flush = 1'b0; out_ready = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    apply('0, 1'b0);
    cycle();
    cycle();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_occ", 64'(occupancy), 64'd0);

    // Single transfer, 1-cycle latency.
    RST_N = 1'b1; out_ready = 1'b1;
    apply(mk(1'b0, 16'h1234, 5'd5), 1'b1);
    cycle();
    check("xfer_valid", 64'(out_valid), 64'd1);
    check("xfer_r1", 64'(R1out_out), 64'h1234);
    check("xfer_we", 64'(WRegEn_out), 64'd1);
    check("xfer_occ", 64'(occupancy), 64'd1);
    apply('0, 1'b0);
    cycle();

    // Backpressure: A, B held, C waits upstream, then drain in order.
    a = mk(1'b0, 16'hA0A0, 5'd1);
    b = mk(1'b0, 16'hB0B0, 5'd2);
    c = mk(1'b0, 16'hC0C0, 5'd3);
    out_ready = 1'b0;
    apply(a, 1'b1); cycle();
    apply(b, 1'b1); cycle();
    apply(c, 1'b1); cycle();
    check("bp_occ", 64'(occupancy), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_main_a", 64'(R1out_out), 64'hA0A0);
    out_ready = 1'b1;
    cycle();
    check("bp_out_b", 64'(R1out_out), 64'hB0B0);
    cycle();
    check("bp_out_c", 64'(R1out_out), 64'hC0C0);
    apply('0, 1'b0);
    cycle();
    check("bp_drained", 64'(out_valid), 64'd0);

    // Flush while FULL with D offered in the same cycle.
    d = mk(1'b0, 16'hD0D0, 5'd4);
    out_ready = 1'b0;
    apply(a, 1'b1); cycle();
    apply(b, 1'b1); cycle();
    flush = 1'b1;
    apply(d, 1'b1); cycle();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; out_ready = 1'b1;
    apply('0, 1'b0);
    cycle();
    cycle();

    // Load-use detection.
    out_ready = 1'b0;
    apply(mk(1'b1, 16'h7777, 5'd7), 1'b1); cycle();
    apply('0, 1'b0);
    id_rs1 = 5'd1; id_rs2 = 5'd7; #1;
    check("lu_hit", 64'(hz_load_use), 64'd1);
    id_rs1 = 5'd3; id_rs2 = 5'd3; #1;
    check("lu_miss", 64'(hz_load_use), 64'd0);
    id_rs2 = 5'd7; flush = 1'b1; #1;
    check("lu_flush", 64'(hz_load_use), 64'd0);
    cycle();
    flush = 1'b0; out_ready = 1'b1;
    apply(mk(1'b1, 16'h0F0F, 5'd0), 1'b1);
    cycle();
    apply('0, 1'b0);
    id_rs1 = 5'd0; id_rs2 = 5'd0; #1;
    check("lu_x0", 64'(hz_load_use), 64'd0);
    check("x0_we", 64'(WRegEn_out), 64'd0);
    check("x0_valid", 64'(out_valid), 64'd1);
    cycle();

    // Reset while FULL overrides an in-flight transfer.
    out_ready = 1'b0;
    apply(a, 1'b1); cycle();
    apply(b, 1'b1); cycle();
    check("mr_full", 64'(occupancy), 64'd2);
    RST_N = 1'b0; out_ready = 1'b1;
    apply(c, 1'b1); cycle();
    check("mr_occ", 64'(occupancy), 64'd0);
    check("mr_in_ready", 64'(in_ready), 64'd1);
    check("mr_r1", 64'(R1out_out), 64'd0);
    check("mr_wreg", 64'(WReg1_out), 64'd0);
    RST_N = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(rnd_bnd(), 1'($urandom_range(0, 2) != 0));
      out_ready = 1'($urandom_range(0, 3) != 0);
      flush     = 1'($urandom_range(0, 19) == 0);
      id_rs1    = 5'($urandom_range(0, 7));
      id_rs2    = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
